conv2_fmap_streamer: RTL and testbench
======================================

// Module: conv2_fmap_streamer
// PURPOSE
//  Transmit side of the conv2 line-buffer stream protocol (new_filter / data_push / data_in).
//  - Reads a stored conv1 feature map from a synchronous-read BRAM, raster order.
//  - Streams it once per filter pass, pulsing new_filter before each pass.
//  - Sits between the conv1 output BRAM and conv2_line_buffer.
// PARAMETERS
//  DATA_WIDTH  64                           word width (packed channels per pixel)
//  FMAP_W      26                           pixels per row (equals line-buffer FIFO_DEPTH)
//  FMAP_H      26                           rows per feature map
//  NUM_PASSES  4                            filter passes streamed per start
//  RD_LAT      2                            BRAM read latency, cycles from mem_en edge to valid mem_dout
//  ADDR_WIDTH  $clog2(FMAP_W*FMAP_H)        BRAM address width
// PORTS
//  clk         in   1           clock
//  reset       in   1           async, active-high reset
//  start       in   1           one-cycle request to begin NUM_PASSES passes
//  hold        in   1           pause issuing new reads
//  busy        out  1           high from accepted start until done
//  done        out  1           one-cycle pulse after final pass drained
//  mem_en      out  1           BRAM read enable
//  mem_addr    out  ADDR_WIDTH  BRAM read address
//  mem_dout    in   DATA_WIDTH  BRAM read data
//  new_filter  out  1           one-cycle pass-start pulse to line buffer
//  data_push   out  1           data_in valid this cycle
//  data_in     out  DATA_WIDTH  pixel word to line buffer
// BEHAVIOUR
//  Reset:
//  - All outputs 0; FSM=IDLE; addr, pass counters and RD_LAT+1-deep valid pipe cleared.
//  - Asynchronous; a reset mid-pass aborts immediately.
//  - No data_push from in-flight reads after reset release.
//  FSM:
//  - IDLE:   start=1 -> START, busy<=1. start while busy is ignored.
//  - START:  exactly 1 cycle, new_filter=1, mem_en=0 -> STREAM.
//  - STREAM: each cycle with hold=0: mem_en=1, mem_addr=addr, addr++.
//            hold=1: mem_en=0, addr frozen.
//            After addr FMAP_W*FMAP_H-1 is issued -> DRAIN; addr resets to 0.
//  - DRAIN:  exactly RD_LAT+1 cycles, no reads (pipe empties).
//            Then pass_cnt<NUM_PASSES-1 -> pass_cnt++, START; else -> DONE.
//  - DONE:   1 cycle, done=1, busy<=0 -> IDLE.
//  Datapath:
//  - valid pipe shifts mem_en each cycle.
//  - data_push is registered: high exactly RD_LAT+1 cycles after its mem_en cycle.
//  - data_in <= mem_dout when pushing, else 0.
//  - hold does not stall in-flight reads; they still push. Line buffer has no backpressure.
//  Invariants:
//  - new_filter never coincides with data_push.
//  - Exactly FMAP_W*FMAP_H pushes per pass, addresses 0..W*H-1 in order, no duplicates or skips.
//  - mem_addr holds its last value when mem_en=0.
// TESTING (FMAP_W=4, FMAP_H=3, NUM_PASSES=2, RD_LAT=2; BRAM model returns data = address)
//  1. start at cycle 0 -> new_filter cycle 1; mem_en cycles 2..13 (addr 0..11);
//     data_push cycles 5..16 with data_in 0..11; new_filter again cycle 17.
//  2. Continue case 1 -> pass-2 pushes cycles 21..32 (data 0..11); done=1 cycle 33;
//     busy=0 from cycle 34.
//  3. hold=1 cycles 6..8 -> mem_en low on those 3 cycles; push gap of 3 cycles;
//     still 12 pushes in order 0..11.
//  4. start re-pulsed at cycles 4 and 20 while busy -> ignored; push/done timing identical to cases 1-2.
//  5. reset asserted cycle 9 for 2 cycles -> all outputs 0 at once; no data_push after release;
//     a new start afterwards restarts at addr 0 with new_filter.
//  6. Defaults (26x26, NUM_PASSES=4), random hold -> 4 new_filter pulses,
//     676 pushes per pass in address order, new_filter never overlaps data_push.

Source files
------------

// File: rtl/conv2_fmap_streamer.sv
// conv2_fmap_streamer: streams a stored conv1 feature map out of a synchronous-read
// BRAM in raster order, once per filter pass, into the conv2 line buffer. Each pass
// is preceded by a one-cycle new_filter pulse; done pulses after the last pass drains.
module conv2_fmap_streamer #(
    parameter int DATA_WIDTH = 64,
    parameter int FMAP_W     = 26,
    parameter int FMAP_H     = 26,
    parameter int NUM_PASSES = 4,
    parameter int RD_LAT     = 2,
    parameter int ADDR_WIDTH = $clog2(FMAP_W * FMAP_H)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  hold,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_dout,
    output logic                  new_filter,
    output logic                  data_push,
    output logic [DATA_WIDTH-1:0] data_in
);

    localparam int NPIX = FMAP_W * FMAP_H;
    localparam int PCW  = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
    localparam int DCW  = (RD_LAT > 0) ? $clog2(RD_LAT + 1) : 1;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(NPIX - 1);
    localparam logic [PCW-1:0]        LAST_PASS  = PCW'(NUM_PASSES - 1);
    localparam logic [DCW-1:0]        LAST_DRAIN = DCW'(RD_LAT);

    typedef enum logic [2:0] {StIdle, StStart, StStream, StDrain, StDone} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH-1:0] last_addr;
    logic [PCW-1:0]        pass_cnt;
    logic [DCW-1:0]        drain_cnt;
    logic [RD_LAT:0]       valid_pipe;

    // A read is issued on every un-held STREAM cycle; when idle the address bus
    // keeps showing the last address actually issued.
    always_comb begin
        mem_en   = (state == StStream) && !hold;
        mem_addr = mem_en ? addr : last_addr;
    end

    // Pass sequencing FSM with registered control pulses and read address counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= StIdle;
            addr       <= '0;
            last_addr  <= '0;
            pass_cnt   <= '0;
            drain_cnt  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            new_filter <= 1'b0;
        end else begin
            done       <= 1'b0;
            new_filter <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        state      <= StStart;
                        busy       <= 1'b1;
                        pass_cnt   <= '0;
                        new_filter <= 1'b1;
                    end
                end
                StStart: begin
                    state <= StStream;
                end
                StStream: begin
                    if (!hold) begin
                        last_addr <= addr;
                        if (addr == LAST_ADDR) begin
                            addr      <= '0;
                            drain_cnt <= '0;
                            state     <= StDrain;
                        end else begin
                            addr <= addr + ADDR_WIDTH'(1);
                        end
                    end
                end
                StDrain: begin
                    // Wait out the read pipe so the next new_filter never meets a push.
                    if (drain_cnt == LAST_DRAIN) begin
                        if (pass_cnt == LAST_PASS) begin
                            state <= StDone;
                            done  <= 1'b1;
                        end else begin
                            pass_cnt   <= pass_cnt + PCW'(1);
                            state      <= StStart;
                            new_filter <= 1'b1;
                        end
                    end else begin
                        drain_cnt <= drain_cnt + DCW'(1);
                    end
                end
                StDone: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign data_push = valid_pipe[RD_LAT];

    // Valid pipe tracks reads in flight; the final stage captures BRAM data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_pipe <= '0;
            data_in    <= '0;
        end else begin
            valid_pipe <= {valid_pipe[RD_LAT-1:0], mem_en};
            data_in    <= valid_pipe[RD_LAT-1] ? mem_dout : '0;
        end
    end

endmodule

// File: tb/tb_conv2_fmap_streamer.sv
// Bench for conv2_fmap_streamer: a small 4x3x2-pass instance with cycle-exact
// expectations and a default-size instance under random hold.
module tb_conv2_fmap_streamer;

    localparam int DW  = 64;
    localparam int SW  = 4;
    localparam int SH  = 3;
    localparam int SP  = 2;
    localparam int SL  = 2;
    localparam int SAW = $clog2(SW * SH);
    localparam int BW  = 26;
    localparam int BH  = 26;
    localparam int BP  = 4;
    localparam int BAW = $clog2(BW * BH);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- small instance ----------------
    logic           s_reset, s_start, s_hold;
    logic           s_busy, s_done, s_mem_en, s_new_filter, s_data_push;
    logic [SAW-1:0] s_mem_addr;
    logic [DW-1:0]  s_mem_dout, s_data_in;
    logic [DW-1:0]  s_m1, s_m2;

    conv2_fmap_streamer #(
        .DATA_WIDTH(DW), .FMAP_W(SW), .FMAP_H(SH), .NUM_PASSES(SP), .RD_LAT(SL)
    ) dut_small (
        .clk(clk), .reset(s_reset), .start(s_start), .hold(s_hold),
        .busy(s_busy), .done(s_done), .mem_en(s_mem_en), .mem_addr(s_mem_addr),
        .mem_dout(s_mem_dout), .new_filter(s_new_filter), .data_push(s_data_push),
        .data_in(s_data_in)
    );

    // Two-cycle BRAM returning its own address as data.
    always @(posedge clk) begin
        if (s_mem_en) s_m1 <= DW'(s_mem_addr);
        s_m2 <= s_m1;
    end
    assign s_mem_dout = s_m2;

    // ---------------- default-size instance ----------------
    logic           b_reset, b_start, b_hold;
    logic           b_busy, b_done, b_mem_en, b_new_filter, b_data_push;
    logic [BAW-1:0] b_mem_addr;
    logic [DW-1:0]  b_mem_dout, b_data_in;
    logic [DW-1:0]  b_m1, b_m2;

    conv2_fmap_streamer dut_big (
        .clk(clk), .reset(b_reset), .start(b_start), .hold(b_hold),
        .busy(b_busy), .done(b_done), .mem_en(b_mem_en), .mem_addr(b_mem_addr),
        .mem_dout(b_mem_dout), .new_filter(b_new_filter), .data_push(b_data_push),
        .data_in(b_data_in)
    );

    always @(posedge clk) begin
        if (b_mem_en) b_m1 <= DW'(b_mem_addr);
        b_m2 <= b_m1;
    end
    assign b_mem_dout = b_m2;

    // ---------------- scoreboard ----------------
    typedef struct {
        int            c;
        logic [DW-1:0] d;
    } ev_t;

    ev_t           push_q[$];
    int            nf_q[$];
    int            done_q[$];
    logic [DW-1:0] bpush_q[$];
    int            b_nf_count = 0;

    task automatic check(input string name, input logic [DW-1:0] got,
                         input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got an event, expected none (cycle %0d)", name, cyc);
    endtask

    // Small-instance monitor: timing and data of every push and pulse.
    always @(negedge clk) begin
        ev_t e;
        int  c;
        if (s_data_push) begin
            if (push_q.size() == 0) unexpected("s_push");
            else begin
                e = push_q.pop_front();
                check("s_push_cycle", DW'(cyc), DW'(e.c));
                check("s_push_data", s_data_in, e.d);
            end
        end
        if (s_new_filter) begin
            check("s_nf_push_overlap", DW'(s_data_push), '0);
            if (nf_q.size() == 0) unexpected("s_new_filter");
            else begin
                c = nf_q.pop_front();
                check("s_new_filter_cycle", DW'(cyc), DW'(c));
            end
        end
        if (s_done) begin
            if (done_q.size() == 0) unexpected("s_done");
            else begin
                c = done_q.pop_front();
                check("s_done_cycle", DW'(cyc), DW'(c));
            end
        end
    end

    // Default-instance monitor: data order only.
    always @(negedge clk) begin
        logic [DW-1:0] d;
        if (b_data_push) begin
            if (bpush_q.size() == 0) unexpected("b_push");
            else begin
                d = bpush_q.pop_front();
                check("b_push_data", b_data_in, d);
            end
        end
        if (b_new_filter) begin
            b_nf_count++;
            check("b_nf_push_overlap", DW'(b_data_push), '0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected events for a full small run started at t0 with an optional hold window.
    task automatic gen_expect(input int t0, input int hlo, input int hhi, output int done_c);
        int sc;
        int c;
        sc = t0 + 1;
        for (int p = 0; p < SP; p++) begin
            nf_q.push_back(sc);
            c = sc + 1;
            for (int i = 0; i < SW * SH; i++) begin
                while (c >= hlo && c <= hhi) c++;
                push_q.push_back('{c + SL + 1, DW'(i)});
                c++;
            end
            sc = c + SL + 1;
        end
        done_c = sc;
        done_q.push_back(sc);
    endtask

    task automatic check_drained(input string name);
        check({name, "_push_q"}, DW'(push_q.size()), '0);
        check({name, "_nf_q"}, DW'(nf_q.size()), '0);
        check({name, "_done_q"}, DW'(done_q.size()), '0);
    endtask

    // One full small run; extra start pulses and a hold window are relative cycles.
    task automatic run_small(input string name, input int hlo, input int hhi,
                             input int s2, input int s3);
        int t0;
        int dc;
        t0 = cyc;
        gen_expect(t0, (hlo < 0) ? -1 : t0 + hlo, (hhi < 0) ? -2 : t0 + hhi, dc);
        for (int r = 0; r <= dc - t0 + 2; r++) begin
            s_start = (r == 0) || (r == s2) || (r == s3);
            s_hold  = (r >= hlo) && (r <= hhi);
            @(negedge clk);
            if (hlo >= 0 && r >= hlo && r <= hhi) check("s_mem_en_hold", DW'(s_mem_en), '0);
            if (r == 1) check("s_busy_after_start", DW'(s_busy), 1);
            if (t0 + r == dc) check("s_busy_at_done", DW'(s_busy), 1);
            if (t0 + r == dc + 1) check("s_busy_after_done", DW'(s_busy), 0);
            tick();
        end
        s_start = 1'b0;
        s_hold  = 1'b0;
        check_drained(name);
    endtask

    initial begin
        int t0;
        int dc;
        bit got_done;

        s_reset = 1'b1; s_start = 1'b0; s_hold = 1'b0;
        b_reset = 1'b1; b_start = 1'b0; b_hold = 1'b0;
        tick();
        tick();
        @(negedge clk);
        check("s_reset_outputs",
              DW'({s_busy, s_done, s_mem_en, s_new_filter, s_data_push, s_mem_addr}), '0);
        check("s_reset_data_in", s_data_in, '0);
        check("b_reset_outputs", DW'({b_busy, b_done, b_mem_en, b_new_filter, b_data_push}), '0);
        tick();
        s_reset = 1'b0;
        b_reset = 1'b0;
        tick();

        // Cases 1-2: plain two-pass run.
        run_small("plain", -1, -1, -1, -1);
        tick();
        // Case 3: hold cycles 6..8.
        run_small("hold", 6, 8, -1, -1);
        tick();
        // Case 4: start re-pulsed while busy.
        run_small("restart_ignored", -1, -1, 4, 20);
        tick();

        // Case 5: reset mid-pass at cycle 9 for 2 cycles.
        t0 = cyc;
        nf_q.push_back(t0 + 1);
        for (int i = 0; i < 4; i++) push_q.push_back('{t0 + 5 + i, DW'(i)});
        for (int r = 0; r <= 15; r++) begin
            s_start = (r == 0);
            if (r == 9) s_reset = 1'b1;
            if (r == 11) s_reset = 1'b0;
            @(negedge clk);
            if (r == 9) begin
                check("s_midreset_outputs",
                      DW'({s_busy, s_done, s_mem_en, s_new_filter, s_data_push, s_mem_addr}),
                      '0);
                check("s_midreset_data_in", s_data_in, '0);
            end
            if (r == 14) check("s_idle_after_reset", DW'(s_busy), 0);
            tick();
        end
        s_start = 1'b0;
        check_drained("reset_abort");
        run_small("after_reset", -1, -1, -1, -1);

        // Case 6: default size with random hold.
        for (int p = 0; p < BP; p++)
            for (int i = 0; i < BW * BH; i++) bpush_q.push_back(DW'(i));
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        got_done = 1'b0;
        for (int k = 0; k < 20000 && !got_done; k++) begin
            b_hold = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            if (b_done) got_done = 1'b1;
            tick();
        end
        b_hold = 1'b0;
        check("b_done_seen", DW'(got_done), 1);
        tick();
        tick();
        tick();
        check("b_new_filter_count", DW'(b_nf_count), DW'(BP));
        check("b_push_q_empty", DW'(bpush_q.size()), '0);
        check("b_busy_end", DW'(b_busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
